cpu_trace_checker: RTL and testbench

CPU_TRACE_CHECKER -- requirements
Module: cpu_trace_checker

---
 rtl/cpu_trace_checker.sv | 101 ++++++++++
 tb/tb_cpu_trace_checker.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_trace_checker.sv
// cpu_trace_checker: streaming parser for CPU trace records, one ASCII char per clock,
// flags semantic errors in accepted records and counts them.
module cpu_trace_checker #(
  parameter int TIME_MAX_DIGITS = 4,
  parameter int GRF_MAX_DIGITS = 4,
  parameter int PC_DIGITS = 8,
  parameter int ADDR_DIGITS = 8,
  parameter int DATA_DIGITS = 8,
  parameter logic [31:0] PC_MIN = 32'h0000_3000,
  parameter logic [31:0] PC_MAX = 32'h0000_6FFF,
  parameter logic [31:0] ADDR_MAX = 32'h0000_2FFF,
  parameter bit ALLOW_UPPER = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       char,
  output logic [1:0]       format_type,
  output logic [2:0]       error_code,
  output logic [CNT_W-1:0] rec_count,
  output logic [CNT_W-1:0] err_count
);
  typedef enum logic [3:0] {
    IDLE, CARET, TIME, AT, PC, COLON, DOLLAR, STAR, GRF, ADDR, SP, LT, EQ, DATA, ACCEPT
  } state_t;
  state_t state, nxt;
  logic [31:0] cnt, pc, addr;
  logic [15:0] grf, grf_nx;
  logic grf_big, is_mem, is_dec, is_hex;
  logic [3:0] hv;
  logic [2:0] err;
  always_comb begin
    is_dec = char >= "0" && char <= "9";
    is_hex = is_dec || (char >= "a" && char <= "f") || (ALLOW_UPPER && char >= "A" && char <= "F");
    hv = is_dec ? char[3:0] : char[3:0] + 4'd9;
    grf_nx = grf * 16'd10 + {12'd0, char[3:0]};
    err = {is_mem && (addr > ADDR_MAX || addr[1:0] != 2'b00),
           !is_mem && grf_big,
           pc < PC_MIN || pc > PC_MAX || pc[1:0] != 2'b00};
    format_type = state == ACCEPT ? (is_mem ? 2'b10 : 2'b01) : 2'b00;
    error_code = state == ACCEPT ? err : 3'b000;
  end
  // Anything not legal below falls back to CARET on '^', else IDLE.
  always_comb begin
    nxt = char == "^" ? CARET : IDLE;
    case (state)
      CARET:  if (is_dec) nxt = TIME;
      TIME:   if (is_dec && cnt < TIME_MAX_DIGITS) nxt = TIME;
              else if (char == "@") nxt = AT;
      AT:     if (is_hex) nxt = PC;
      PC:     if (is_hex && cnt < PC_DIGITS) nxt = PC;
              else if (char == ":" && cnt == PC_DIGITS) nxt = COLON;
      COLON:  nxt = char == " " ? COLON : char == "$" ? DOLLAR : char == "*" ? STAR : nxt;
      DOLLAR: if (is_dec) nxt = GRF;
      GRF:    if (is_dec && cnt < GRF_MAX_DIGITS) nxt = GRF;
              else if (char == " ") nxt = SP;
              else if (char == "<") nxt = LT;
      STAR:   if (is_hex) nxt = ADDR;
      ADDR:   if (is_hex && cnt < ADDR_DIGITS) nxt = ADDR;
              else if (cnt == ADDR_DIGITS && char == " ") nxt = SP;
              else if (cnt == ADDR_DIGITS && char == "<") nxt = LT;
      SP:     nxt = char == " " ? SP : char == "<" ? LT : nxt;
      LT:     if (char == "=") nxt = EQ;
      EQ:     nxt = char == " " ? EQ : is_hex ? DATA : nxt;
      DATA:   if (is_hex && cnt < DATA_DIGITS) nxt = DATA;
              else if (char == "#" && cnt == DATA_DIGITS) nxt = ACCEPT;
      default: ;
    endcase
  end
  always_ff @(posedge clk) state <= reset ? IDLE : nxt;
  always_ff @(posedge clk) begin
    if (reset || nxt == CARET) begin
      cnt <= '0;
      pc <= '0;
      addr <= '0;
      grf <= '0;
      grf_big <= 1'b0;
      is_mem <= 1'b0;
    end else begin
      if (nxt == TIME || nxt == PC || nxt == GRF || nxt == ADDR || nxt == DATA)
        cnt <= nxt == state ? cnt + 32'd1 : 32'd1;
      if (nxt == PC) pc <= {pc[27:0], hv};
      if (nxt == ADDR) addr <= {addr[27:0], hv};
      if (nxt == GRF) begin
        grf <= grf_nx;
        grf_big <= grf_big || grf_nx > 16'd31;
      end
      if (nxt == STAR) is_mem <= 1'b1;
    end
  end
  // Fields are frozen once DATA is reached, so err is already final on the accepting edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rec_count <= '0;
      err_count <= '0;
    end else if (nxt == ACCEPT) begin
      rec_count <= rec_count + CNT_W'(rec_count != '1);
      err_count <= err_count + CNT_W'(err != 3'b000 && err_count != '1);
    end
  end
endmodule

// File: tb/tb_cpu_trace_checker.sv
// tb_cpu_trace_checker: directed-vector bench for cpu_trace_checker, with a second
// instance built with ALLOW_UPPER=1 for the uppercase-hex case.
module tb_cpu_trace_checker;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] char = ".";
  logic [1:0] format_type, format_type_up;
  logic [2:0] error_code, error_code_up;
  logic [15:0] rec_count, err_count, rec_count_up, err_count_up;
  int checks = 0;
  int errors = 0;
  int exp_rec = 0;
  int exp_err = 0;

  always #5 clk = ~clk;

  cpu_trace_checker dut (
    .clk(clk), .reset(reset), .char(char), .format_type(format_type),
    .error_code(error_code), .rec_count(rec_count), .err_count(err_count)
  );

  cpu_trace_checker #(.ALLOW_UPPER(1)) dut_up (
    .clk(clk), .reset(reset), .char(char), .format_type(format_type_up),
    .error_code(error_code_up), .rec_count(rec_count_up), .err_count(err_count_up)
  );

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      char = s[i];
    end
  endtask

  task automatic close_rec;
    @(negedge clk);
    char = ".";
  endtask

  task automatic test_reset;
    char = "^";
    repeat (2) @(negedge clk);
    checks += 4;
    if (format_type !== 2'b00) begin errors++; $display("FAIL reset format_type got %b want 00", format_type); end
    if (error_code !== 3'b000) begin errors++; $display("FAIL reset error_code got %b want 000", error_code); end
    if (rec_count !== 16'd0) begin errors++; $display("FAIL reset rec_count got %0d want 0", rec_count); end
    if (err_count !== 16'd0) begin errors++; $display("FAIL reset err_count got %0d want 0", err_count); end
    reset = 1'b0;
    char = ".";
  endtask

  task automatic test_records;
    string recs[9];
    logic [1:0] fts[9];
    logic [2:0] ecs[9];
    recs = '{"^10@00003010: $5 <=0000000a#",
             "^1@00003004:*00000010<=12345678#",
             "^1@00003004:*00003001 <=00000000#",
             "^7@00002ffe:$40<=00000000#",
             "^3@00003000:$0031<=00000000#",
             "^3@00003000:$32<=00000000#",
             "^3@00006ffc:$1<=00000000#",
             "^3@00007000:$1<=00000000#",
             "^9999@00003000:  *00002ffc  <=  deadbeef#"};
    fts = '{2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    ecs = '{3'b000, 3'b000, 3'b100, 3'b011, 3'b000, 3'b010, 3'b000, 3'b001, 3'b000};
    for (int i = 0; i < 9; i++) begin
      send(recs[i]);
      close_rec();
      exp_rec++;
      if (ecs[i] != 3'b000) exp_err++;
      checks += 4;
      if (format_type !== fts[i]) begin errors++; $display("FAIL rec%0d format_type got %b want %b", i, format_type, fts[i]); end
      if (error_code !== ecs[i]) begin errors++; $display("FAIL rec%0d error_code got %b want %b", i, error_code, ecs[i]); end
      if (rec_count !== 16'(exp_rec)) begin errors++; $display("FAIL rec%0d rec_count got %0d want %0d", i, rec_count, exp_rec); end
      if (err_count !== 16'(exp_err)) begin errors++; $display("FAIL rec%0d err_count got %0d want %0d", i, err_count, exp_err); end
      @(negedge clk);
      checks += 2;
      if (format_type !== 2'b00) begin errors++; $display("FAIL rec%0d one_cycle format_type got %b want 00", i, format_type); end
      if (error_code !== 3'b000) begin errors++; $display("FAIL rec%0d one_cycle error_code got %b want 000", i, error_code); end
    end
  endtask

  task automatic test_reject;
    string recs[7];
    recs = '{"^12@0000300:$1<=00000000#",
             "^12345@00003000:$1<=00000000#",
             "^1@00003000 :$1<=00000000#",
             "^1@00003000:$1< =00000000#",
             "^1@00003000:$ 1<=00000000#",
             "^1@00003000:$1<=000000000#",
             "^1@00003000:*0000300<=00000000#"};
    for (int i = 0; i < 7; i++) begin
      send(recs[i]);
      close_rec();
      checks += 3;
      if (format_type !== 2'b00) begin errors++; $display("FAIL reject%0d format_type got %b want 00", i, format_type); end
      if (rec_count !== 16'(exp_rec)) begin errors++; $display("FAIL reject%0d rec_count got %0d want %0d", i, rec_count, exp_rec); end
      if (err_count !== 16'(exp_err)) begin errors++; $display("FAIL reject%0d err_count got %0d want %0d", i, err_count, exp_err); end
    end
  endtask

  task automatic test_upper;
    send("^1@00003000:$1<=0000000A#");
    close_rec();
    checks += 4;
    if (format_type !== 2'b00) begin errors++; $display("FAIL upper_lc format_type got %b want 00", format_type); end
    if (rec_count !== 16'(exp_rec)) begin errors++; $display("FAIL upper_lc rec_count got %0d want %0d", rec_count, exp_rec); end
    if (format_type_up !== 2'b01) begin errors++; $display("FAIL upper_uc format_type got %b want 01", format_type_up); end
    if (error_code_up !== 3'b000) begin errors++; $display("FAIL upper_uc error_code got %b want 000", error_code_up); end
  endtask

  task automatic test_restart;
    send("^1@0^5@00003000:$0<=00000000#");
    close_rec();
    exp_rec++;
    checks += 3;
    if (format_type !== 2'b01) begin errors++; $display("FAIL restart format_type got %b want 01", format_type); end
    if (error_code !== 3'b000) begin errors++; $display("FAIL restart error_code got %b want 000", error_code); end
    if (rec_count !== 16'(exp_rec)) begin errors++; $display("FAIL restart rec_count got %0d want %0d", rec_count, exp_rec); end
  endtask

  task automatic test_back_to_back;
    send("^2@00003000:$3<=00000000#");
    @(negedge clk);
    char = "^";
    exp_rec++;
    checks += 2;
    if (format_type !== 2'b01) begin errors++; $display("FAIL b2b_first format_type got %b want 01", format_type); end
    if (rec_count !== 16'(exp_rec)) begin errors++; $display("FAIL b2b_first rec_count got %0d want %0d", rec_count, exp_rec); end
    send("4@00003000:*00000004<=00000000#");
    close_rec();
    exp_rec++;
    checks += 3;
    if (format_type !== 2'b10) begin errors++; $display("FAIL b2b_second format_type got %b want 10", format_type); end
    if (error_code !== 3'b000) begin errors++; $display("FAIL b2b_second error_code got %b want 000", error_code); end
    if (rec_count !== 16'(exp_rec)) begin errors++; $display("FAIL b2b_second rec_count got %0d want %0d", rec_count, exp_rec); end
  endtask

  task automatic test_reset_mid;
    string tail;
    tail = "3000:$1<=00000000#";
    send("^5@0000");
    @(negedge clk);
    reset = 1'b1;
    char = "3";
    @(negedge clk);
    reset = 1'b0;
    exp_rec = 0;
    exp_err = 0;
    checks += 2;
    if (rec_count !== 16'd0) begin errors++; $display("FAIL reset_mid rec_count got %0d want 0", rec_count); end
    if (err_count !== 16'd0) begin errors++; $display("FAIL reset_mid err_count got %0d want 0", err_count); end
    for (int i = 0; i < tail.len(); i++) begin
      char = tail[i];
      @(negedge clk);
      checks++;
      if (format_type !== 2'b00) begin errors++; $display("FAIL reset_mid char%0d format_type got %b want 00", i, format_type); end
    end
    char = ".";
    @(negedge clk);
    checks += 2;
    if (format_type !== 2'b00) begin errors++; $display("FAIL reset_mid final format_type got %b want 00", format_type); end
    if (rec_count !== 16'd0) begin errors++; $display("FAIL reset_mid final rec_count got %0d want 0", rec_count); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_records();
    test_reject();
    test_upper();
    test_restart();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
